// File: rtl/pit_pkg.sv
// rtl/pit_pkg.sv - shared constants and types for the interval timer controller
// Holds register offsets, ctrl/status bit positions, FSM encoding and channel limit.
package pit_pkg;

    localparam int MAX_CH = 4;

    localparam logic [1:0] REG_CNT_LO = 2'd0;
    localparam logic [1:0] REG_CNT_HI = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_REP_BIT  = 1;
    localparam int CTRL_MASK_BIT = 2;

    localparam int ST_PEND_BIT = 0;
    localparam int ST_OVR_BIT  = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2
    } pit_state_e;

endpackage

// File: rtl/pit_prio_arb.sv
// rtl/pit_prio_arb.sv - combinational fixed-priority encoder, lowest index wins
// Ports: valid[NUM_CH] requests in; any = at least one request; id = winning index.
module pit_prio_arb
    import pit_pkg::*;
#(
    parameter int NUM_CH = MAX_CH
) (
    input  logic [NUM_CH-1:0] valid,
    output logic              any,
    output logic [1:0]        id
);

    // Scan from the top down so the lowest set index is the last assignment.
    always_comb begin
        any = 1'b0;
        id  = 2'd0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (valid[i]) begin
                any = 1'b1;
                id  = 2'(i);
            end
        end
    end

endmodule

// File: rtl/pit_ctrl.sv
// rtl/pit_ctrl.sv - timer channel register file, pending capture and interrupt FSM
// Ports: clk/rst_n (sync, active-low); wr_en/wr_addr/wr_data byte register writes;
// rd_addr/rd_data registered reads; ch_counter/ch_enable/ch_repeating/ch_write_enable
// per-channel configuration; ch_irq timer pulses in; irq/irq_id/irq_ack host handshake.
module pit_ctrl
    import pit_pkg::*;
#(
    parameter int NUM_CH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [3:0]           wr_addr,
    input  logic [7:0]           wr_data,
    input  logic [3:0]           rd_addr,
    output logic [7:0]           rd_data,
    output logic [16*NUM_CH-1:0] ch_counter,
    output logic [NUM_CH-1:0]    ch_enable,
    output logic [NUM_CH-1:0]    ch_repeating,
    output logic [NUM_CH-1:0]    ch_write_enable,
    input  logic [NUM_CH-1:0]    ch_irq,
    output logic                 irq,
    output logic [1:0]           irq_id,
    input  logic                 irq_ack
);

    // Storage is sized for the full address space; channels beyond NUM_CH are
    // never written and receive no interrupts, so they stay at reset values.
    logic [7:0]        cnt_lo_q [MAX_CH];
    logic [7:0]        cnt_hi_q [MAX_CH];
    logic [MAX_CH-1:0] en_q, rep_q, mask_q, pend_q, ovr_q, we_q;
    logic [MAX_CH-1:0] mask_n, pend_n, ovr_n, clr;
    logic [MAX_CH-1:0] irq_ext, ch_exists, eligible;

    pit_state_e state_q, state_n;
    logic [1:0] id_q;
    logic       arb_any;
    logic [1:0] arb_id;

    logic [1:0] wr_ch, wr_reg, rd_ch, rd_reg;
    logic       wr_ok, ctrl_wr, stat_wr, ack_clr;
    logic [7:0] rd_mux;

    for (genvar g = 0; g < MAX_CH; g++) begin : g_ch
        if (g < NUM_CH) begin : g_on
            assign irq_ext[g]   = ch_irq[g];
            assign ch_exists[g] = 1'b1;
            assign ch_counter[16*g +: 16] = {cnt_hi_q[g], cnt_lo_q[g]};
        end else begin : g_off
            assign irq_ext[g]   = 1'b0;
            assign ch_exists[g] = 1'b0;
        end
    end

    assign ch_enable       = en_q[NUM_CH-1:0];
    assign ch_repeating    = rep_q[NUM_CH-1:0];
    assign ch_write_enable = we_q[NUM_CH-1:0];

    assign wr_ch   = wr_addr[3:2];
    assign wr_reg  = wr_addr[1:0];
    assign rd_ch   = rd_addr[3:2];
    assign rd_reg  = rd_addr[1:0];
    assign wr_ok   = wr_en && ch_exists[wr_ch];
    assign ctrl_wr = wr_ok && (wr_reg == REG_CTRL);
    assign stat_wr = wr_ok && (wr_reg == REG_STATUS);
    assign ack_clr = (state_q == REQ) && irq_ack;

    // Counter and ctrl registers; the high-byte write is the commit point.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_CH; i++) begin
                cnt_lo_q[i] <= '0;
                cnt_hi_q[i] <= '0;
            end
            en_q  <= '0;
            rep_q <= '0;
            we_q  <= '0;
        end else begin
            we_q <= '0;
            if (wr_ok) begin
                case (wr_reg)
                    REG_CNT_LO: cnt_lo_q[wr_ch] <= wr_data;
                    REG_CNT_HI: begin
                        cnt_hi_q[wr_ch] <= wr_data;
                        we_q[wr_ch]     <= 1'b1;
                    end
                    REG_CTRL: begin
                        en_q[wr_ch]  <= wr_data[CTRL_EN_BIT];
                        rep_q[wr_ch] <= wr_data[CTRL_REP_BIT];
                    end
                    default: ;
                endcase
            end
        end
    end

    // Sources that clear a pending bit this cycle: disable via ctrl, or host ack.
    always_comb begin
        clr = '0;
        if (ctrl_wr && !wr_data[CTRL_EN_BIT]) clr[wr_ch] = 1'b1;
        if (ack_clr) clr[id_q] = 1'b1;
    end

    // A fresh timer pulse always wins over a clear; it only counts as an overrun
    // when the previous event is still outstanding and not being retired now.
    always_comb begin
        mask_n = mask_q;
        pend_n = pend_q;
        ovr_n  = ovr_q;
        if (ctrl_wr) mask_n[wr_ch] = wr_data[CTRL_MASK_BIT];
        if (stat_wr && wr_data[ST_OVR_BIT]) ovr_n[wr_ch] = 1'b0;
        for (int c = 0; c < MAX_CH; c++) begin
            if (irq_ext[c]) begin
                if (pend_q[c] && !clr[c]) ovr_n[c] = 1'b1;
                pend_n[c] = 1'b1;
            end else if (clr[c]) begin
                pend_n[c] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mask_q <= '0;
            pend_q <= '0;
            ovr_q  <= '0;
        end else begin
            mask_q <= mask_n;
            pend_q <= pend_n;
            ovr_q  <= ovr_n;
        end
    end

    assign eligible = pend_q & ~mask_q;

    pit_prio_arb #(.NUM_CH(NUM_CH)) u_arb (
        .valid (eligible[NUM_CH-1:0]),
        .any   (arb_any),
        .id    (arb_id)
    );

    // FSM state register; the served channel is latched only on entry to REQ.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            id_q    <= 2'd0;
        end else begin
            state_q <= state_n;
            if (state_q == IDLE && arb_any) id_q <= arb_id;
        end
    end

    // REQ looks at next-cycle pending/mask so a disable or mask write drops irq
    // at the very next edge instead of one cycle late.
    always_comb begin
        state_n = state_q;
        case (state_q)
            IDLE: if (arb_any) state_n = REQ;
            REQ:  if (irq_ack || !pend_n[id_q] || mask_n[id_q]) state_n = GAP;
            GAP:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        irq    = (state_q == REQ);
        irq_id = id_q;
    end

    // Reads see register state before any same-cycle write lands.
    always_comb begin
        rd_mux = '0;
        if (ch_exists[rd_ch]) begin
            case (rd_reg)
                REG_CNT_LO: rd_mux = cnt_lo_q[rd_ch];
                REG_CNT_HI: rd_mux = cnt_hi_q[rd_ch];
                REG_CTRL:   rd_mux = {5'd0, mask_q[rd_ch], rep_q[rd_ch], en_q[rd_ch]};
                default:    rd_mux = {6'd0, ovr_q[rd_ch], pend_q[rd_ch]};
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) rd_data <= '0;
        else        rd_data <= rd_mux;
    end

endmodule

// File: tb/tb_pit_ctrl.sv
// tb/tb_pit_ctrl.sv - scoreboard testbench for pit_ctrl
module tb_pit_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [7:0]  wr_data = '0;
    logic [3:0]  rd_addr = '0;
    logic [7:0]  rd_data;
    logic [63:0] ch_counter;
    logic [3:0]  ch_enable, ch_repeating, ch_write_enable;
    logic [3:0]  ch_irq = '0;
    logic        irq;
    logic [1:0]  irq_id;
    logic        irq_ack = 1'b0;

    always #5 clk = ~clk;

    pit_ctrl #(.NUM_CH(4)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .wr_en           (wr_en),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data),
        .rd_addr         (rd_addr),
        .rd_data         (rd_data),
        .ch_counter      (ch_counter),
        .ch_enable       (ch_enable),
        .ch_repeating    (ch_repeating),
        .ch_write_enable (ch_write_enable),
        .ch_irq          (ch_irq),
        .irq             (irq),
        .irq_id          (irq_id),
        .irq_ack         (irq_ack)
    );

    typedef struct {
        logic [7:0]  rd;
        logic        irq;
        logic [1:0]  id;
        logic [3:0]  we;
        logic [63:0] cnt;
        logic [3:0]  en;
        logic [3:0]  rep;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model: plain per-channel values plus "who is being served".
    logic [15:0] m_cnt [4];
    logic [3:0]  m_en, m_rep, m_msk, m_pend, m_ovr;
    int          serving;
    bit          in_gap;
    int          last_id;

    function automatic void model_reset();
        for (int c = 0; c < 4; c++) m_cnt[c] = '0;
        m_en = '0; m_rep = '0; m_msk = '0; m_pend = '0; m_ovr = '0;
        serving = -1; in_gap = 1'b0; last_id = 0;
    endfunction

    function automatic logic [7:0] model_read(input logic [3:0] a);
        int c = int'(a[3:2]);
        case (a[1:0])
            2'd0:    return m_cnt[c][7:0];
            2'd1:    return m_cnt[c][15:8];
            2'd2:    return {5'd0, m_msk[c], m_rep[c], m_en[c]};
            default: return {6'd0, m_ovr[c], m_pend[c]};
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // One clock of stimulus; the expected post-edge outputs go to the scoreboard.
    task automatic cyc(input bit rst, input bit we, input logic [3:0] wa, input logic [7:0] wd,
                       input logic [3:0] ra, input logic [3:0] irqs, input bit ack);
        exp_t e;
        int wc, wreg, pick;
        bit ackd;
        logic [3:0] clr;
        @(negedge clk);
        rst_n = !rst; wr_en = we; wr_addr = wa; wr_data = wd;
        rd_addr = ra; ch_irq = irqs; irq_ack = ack;
        if (rst) begin
            model_reset();
            e.rd = '0;
        end else begin
            e.rd = model_read(ra);
            wc = int'(wa[3:2]);
            wreg = int'(wa[1:0]);
            pick = -1;
            for (int c = 3; c >= 0; c--) if (m_pend[c] && !m_msk[c]) pick = c;
            ackd = ack && (serving >= 0);
            clr = '0;
            if (we && wreg == 2 && !wd[0]) clr[wc] = 1'b1;
            if (ackd) clr[serving] = 1'b1;
            e.we = '0;
            if (we) begin
                case (wreg)
                    0: m_cnt[wc][7:0] = wd;
                    1: begin m_cnt[wc][15:8] = wd; e.we[wc] = 1'b1; end
                    2: begin m_en[wc] = wd[0]; m_rep[wc] = wd[1]; m_msk[wc] = wd[2]; end
                    default: if (wd[1]) m_ovr[wc] = 1'b0;
                endcase
            end
            for (int c = 0; c < 4; c++) begin
                if (irqs[c]) begin
                    if (m_pend[c] && !clr[c]) m_ovr[c] = 1'b1;
                    m_pend[c] = 1'b1;
                end else if (clr[c]) begin
                    m_pend[c] = 1'b0;
                end
            end
            if (serving >= 0) begin
                if (ackd || !m_pend[serving] || m_msk[serving]) begin
                    serving = -1;
                    in_gap = 1'b1;
                end
            end else if (in_gap) begin
                in_gap = 1'b0;
            end else if (pick >= 0) begin
                serving = pick;
                last_id = pick;
            end
        end
        if (rst) e.we = '0;
        e.irq = (serving >= 0);
        e.id  = 2'(last_id);
        e.cnt = {m_cnt[3], m_cnt[2], m_cnt[1], m_cnt[0]};
        e.en  = m_en;
        e.rep = m_rep;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n, input logic [3:0] ra);
        for (int i = 0; i < n; i++) cyc(0, 0, 4'h0, 8'h00, ra, 4'h0, 0);
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d, input logic [3:0] ra);
        cyc(0, 1, a, d, ra, 4'h0, 0);
    endtask

    // Monitor: every cycle after the edge, pop one expectation and compare.
    always @(posedge clk) begin : monitor
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("rd_data", 64'(rd_data), 64'(e.rd));
            check("irq", 64'(irq), 64'(e.irq));
            if (e.irq) check("irq_id", 64'(irq_id), 64'(e.id));
            check("ch_write_enable", 64'(ch_write_enable), 64'(e.we));
            check("ch_counter", ch_counter, e.cnt);
            check("ch_enable", 64'(ch_enable), 64'(e.en));
            check("ch_repeating", 64'(ch_repeating), 64'(e.rep));
        end
    end

    initial begin
        model_reset();
        cyc(1, 0, 4'h0, 8'h00, 4'h0, 4'h0, 0);
        cyc(1, 0, 4'h0, 8'h00, 4'h0, 4'h0, 0);
        for (int a = 0; a < 16; a++) idle(1, 4'(a));

        wr(4'h4, 8'h34, 4'h4);
        wr(4'h5, 8'h12, 4'h5);
        idle(2, 4'h5);

        wr(4'h2, 8'h01, 4'h2);
        wr(4'hA, 8'h01, 4'hA);
        cyc(0, 0, 4'h0, 8'h00, 4'h3, 4'b0101, 0);
        idle(3, 4'h3);
        cyc(0, 0, 4'h0, 8'h00, 4'h3, 4'h0, 1);
        idle(3, 4'hB);
        cyc(0, 0, 4'h0, 8'h00, 4'hB, 4'h0, 1);
        idle(2, 4'hB);
        idle(1, 4'h3);

        cyc(0, 0, 4'h0, 8'h00, 4'hF, 4'b1000, 0);
        idle(1, 4'hF);
        cyc(0, 0, 4'h0, 8'h00, 4'hF, 4'b1000, 0);
        idle(2, 4'hF);
        wr(4'hF, 8'h02, 4'hF);
        idle(2, 4'hF);
        cyc(0, 0, 4'h0, 8'h00, 4'hF, 4'h0, 1);
        idle(3, 4'hF);

        wr(4'h6, 8'h04, 4'h7);
        cyc(0, 0, 4'h0, 8'h00, 4'h7, 4'b0010, 0);
        idle(3, 4'h7);
        wr(4'h6, 8'h00, 4'h7);
        idle(3, 4'h7);
        cyc(0, 0, 4'h0, 8'h00, 4'h7, 4'h0, 1);
        idle(3, 4'h7);

        cyc(0, 0, 4'h0, 8'h00, 4'h3, 4'b0001, 0);
        idle(2, 4'h3);
        wr(4'h2, 8'h00, 4'h3);
        idle(3, 4'h3);

        for (int i = 0; i < 3000; i++) begin
            logic [3:0] irqs;
            for (int b = 0; b < 4; b++) irqs[b] = ($urandom_range(0, 7) == 0);
            cyc(($urandom_range(0, 255) == 0), ($urandom_range(0, 1) == 1),
                4'($urandom), 8'($urandom), 4'($urandom), irqs,
                ($urandom_range(0, 2) == 0));
        end
        idle(2, 4'h0);

        @(posedge clk);
        #2;
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
